// File: rtl/tlc_input_conditioner.sv
// Input conditioning for the traffic light controller: sensor synchronisation and debouncing,
// minute-of-day clock, and registered peak/off-peak mode derived from two daily windows.
`timescale 1ns/1ps
module tlc_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int TICKS_PER_MIN   = 60,
   parameter int MIN_PER_DAY     = 1440,
   parameter int PEAK1_START     = 420,
   parameter int PEAK1_END       = 600,
   parameter int PEAK2_START     = 1020,
   parameter int PEAK2_END       = 1200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sensor1_raw,
   input  logic        sensor2_raw,
   input  logic        tod_load,
   input  logic [10:0] tod_load_min,
   input  logic        force_peak,
   input  logic        force_offpeak,
   output logic        sensor1,
   output logic        sensor2,
   output logic        peak,
   output logic [10:0] tod_min,
   output logic        minute_tick
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TICK_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MIN - 1);
   localparam logic [10:0]       DAY_LEN   = 11'(MIN_PER_DAY);
   localparam logic [10:0]       DAY_LAST  = 11'(MIN_PER_DAY - 1);
   localparam logic [10:0]       P1_START  = 11'(PEAK1_START);
   localparam logic [10:0]       P1_END    = 11'(PEAK1_END);
   localparam logic [10:0]       P2_START  = 11'(PEAK2_START);
   localparam logic [10:0]       P2_END    = 11'(PEAK2_END);

   logic [1:0] raw;
   logic [1:0] sensor_vec;

   assign raw = {sensor2_raw, sensor1_raw};

   // Two identical, independent sensor channels: synchroniser chain feeding a debouncer.
   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   out_q, out_d;
      logic                   synced;

      assign synced = sync_q[SYNC_STAGES-1];

      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      always_comb begin
         sync_d = {sync_q[SYNC_STAGES-2:0], raw[ch]};
         cnt_d  = cnt_q + CNT_W'(1);
         out_d  = out_q;
         if (synced == out_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            out_d = synced;
            cnt_d = '0;
         end
      end

      // NOTE: sequential state uses non-blocking assignments only, so flops update together.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
         end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
         end
      end

      assign sensor_vec[ch] = out_q;
   end

   logic [TICK_W-1:0] tick_q, tick_d;
   logic [10:0]       tod_q, tod_d;
   logic              minute_tick_q, minute_tick_d;
   logic              peak_q, peak_d;
   logic              in_window;

   // A load wins over the minute increment and restarts the prescaler without a tick.
   always_comb begin
      tick_d        = tick_q + TICK_W'(1);
      tod_d         = tod_q;
      minute_tick_d = 1'b0;
      if (tod_load) begin
         tod_d  = (tod_load_min >= DAY_LEN) ? '0 : tod_load_min;
         tick_d = '0;
      end else if (tick_q == TICK_LAST) begin
         tick_d        = '0;
         tod_d         = (tod_q == DAY_LAST) ? '0 : tod_q + 11'd1;
         minute_tick_d = 1'b1;
      end
   end

   // Window test on the registered minute, so peak lags a minute change by one cycle.
   always_comb begin
      in_window = ((tod_q >= P1_START) && (tod_q < P1_END)) ||
                  ((tod_q >= P2_START) && (tod_q < P2_END));
      peak_d    = force_peak | (~force_offpeak & in_window);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_q        <= '0;
         tod_q         <= '0;
         minute_tick_q <= 1'b0;
         peak_q        <= 1'b0;
      end else begin
         tick_q        <= tick_d;
         tod_q         <= tod_d;
         minute_tick_q <= minute_tick_d;
         peak_q        <= peak_d;
      end
   end

   assign sensor1     = sensor_vec[0];
   assign sensor2     = sensor_vec[1];
   assign tod_min     = tod_q;
   assign minute_tick = minute_tick_q;
   assign peak        = peak_q;

endmodule

// File: tb/tb_tlc_input_conditioner.sv
// Directed and randomized bench for tlc_input_conditioner, checked against a window/arithmetic
// reference model: debounce = "last DEBOUNCE_CYCLES synchronised samples agree", clock = base+cycles/T.
`timescale 1ns/1ps
module tb_tlc_input_conditioner;

   localparam int SYNC = 2;
   localparam int DC   = 8;
   localparam int T    = 4;
   localparam int MPD  = 1440;

   logic        clk = 1'b0;
   logic        reset;
   logic        s1r, s2r;
   logic        tod_load;
   logic [10:0] tod_load_min;
   logic        fp, fo;
   logic        sensor1, sensor2, peak, minute_tick;
   logic [10:0] tod_min;

   always #5 clk = ~clk;

   tlc_input_conditioner #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DC),
      .TICKS_PER_MIN  (T)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sensor1_raw  (s1r),
      .sensor2_raw  (s2r),
      .tod_load     (tod_load),
      .tod_load_min (tod_load_min),
      .force_peak   (fp),
      .force_offpeak(fo),
      .sensor1      (sensor1),
      .sensor2      (sensor2),
      .peak         (peak),
      .tod_min      (tod_min),
      .minute_tick  (minute_tick)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model state: raw samples per edge, oldest first.
   bit h1[$];
   bit h2[$];
   bit m_s1, m_s2, m_peak, m_tick;
   int m_base, m_cyc;

   function automatic int m_tod();
      return (m_base + m_cyc / T) % MPD;
   endfunction

   function automatic bit in_win(input int t);
      return (t >= 420 && t < 600) || (t >= 1020 && t < 1200);
   endfunction

   // Returns the common level of the samples the debouncer has judged, or -1 if they differ.
   function automatic int window_level(input int ch);
      int v;
      v = (ch == 0) ? int'(h1[0]) : int'(h2[0]);
      for (int i = 1; i < DC; i++)
         if (((ch == 0) ? int'(h1[i]) : int'(h2[i])) != v) return -1;
      return v;
   endfunction

   task automatic model_reset();
      h1.delete();
      h2.delete();
      for (int i = 0; i < SYNC + DC; i++) begin
         h1.push_back(1'b0);
         h2.push_back(1'b0);
      end
      m_s1 = 0; m_s2 = 0; m_peak = 0; m_tick = 0;
      m_base = 0; m_cyc = 0;
   endtask

   task automatic check_outputs();
      check("sensor1", 32'(sensor1), 32'(m_s1));
      check("sensor2", 32'(sensor2), 32'(m_s2));
      check("tod_min", 32'(tod_min), m_tod());
      check("minute_tick", 32'(minute_tick), 32'(m_tick));
      check("peak", 32'(peak), 32'(m_peak));
   endtask

   task automatic step();
      int prev_tod, lvl;
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         prev_tod = m_tod();
         h1.push_back(s1r); void'(h1.pop_front());
         h2.push_back(s2r); void'(h2.pop_front());
         lvl = window_level(0); if (lvl >= 0) m_s1 = (lvl == 1);
         lvl = window_level(1); if (lvl >= 0) m_s2 = (lvl == 1);
         m_peak = fp ? 1'b1 : (fo ? 1'b0 : in_win(prev_tod));
         if (tod_load) begin
            m_base = (int'(tod_load_min) < MPD) ? int'(tod_load_min) : 0;
            m_cyc  = 0;
            m_tick = 0;
         end else begin
            m_cyc++;
            m_tick = (m_cyc % T == 0);
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic load_tod(input int v);
      tod_load     = 1'b1;
      tod_load_min = 11'(v);
      step();
      tod_load     = 1'b0;
   endtask

   int n;
   int ticks;
   bit dropped;

   initial begin
      s1r = 0; s2r = 0; tod_load = 0; tod_load_min = '0; fp = 0; fo = 0;
      model_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      check_outputs();
      repeat (3) step();
      reset = 1'b1;

      // Both sensors rise; sensor1 must follow on edge 10.
      s1r = 1; s2r = 1;
      n = 0;
      do begin step(); n++; end while (sensor1 !== 1'b1 && n < 40);
      check("t1_rise_latency", n, 10);
      repeat (5) step();

      // Reset mid-operation clears outputs without a clock edge.
      reset = 1'b0;
      #1;
      check("t1_rst_sensor1", 32'(sensor1), 0);
      check("t1_rst_sensor2", 32'(sensor2), 0);
      check("t1_rst_tod", 32'(tod_min), 0);
      check("t1_rst_tick", 32'(minute_tick), 0);
      check("t1_rst_peak", 32'(peak), 0);
      model_reset();
      repeat (2) step();
      reset = 1'b1;
      n = 0;
      do begin step(); n++; end while (sensor1 !== 1'b1 && n < 40);
      check("t1_post_reset_latency", n, 10);
      check("t1_sensor2_same_edge", 32'(sensor2), 1);

      // Bounce on sensor1.
      s1r = 0; s2r = 0;
      repeat (12) step();
      s1r = 1; repeat (5) step();
      s1r = 0; step();
      s1r = 1;
      n = 0;
      do begin step(); n++; end while (sensor1 !== 1'b1 && n < 40);
      check("t2_bounce_latency", n, 10);
      check("t2_sensor2_low", 32'(sensor2), 0);

      // Short drop on sensor2 is filtered, held drop falls on edge 10.
      s2r = 1;
      repeat (12) step();
      check("t3_sensor2_high", 32'(sensor2), 1);
      dropped = 0;
      s2r = 0;
      repeat (7) begin step(); if (sensor2 !== 1'b1) dropped = 1; end
      s2r = 1;
      repeat (12) begin step(); if (sensor2 !== 1'b1) dropped = 1; end
      check("t3_no_drop", 32'(dropped), 0);
      s2r = 0;
      n = 0;
      do begin step(); n++; end while (sensor2 !== 1'b0 && n < 40);
      check("t3_fall_latency", n, 10);

      // Day wrap.
      load_tod(1439);
      check("t4_loaded", 32'(tod_min), 1439);
      ticks = 0;
      repeat (4) begin step(); ticks += int'(minute_tick); end
      check("t4_wrap", 32'(tod_min), 0);
      check("t4_ticks", ticks, 1);
      check("t4_peak", 32'(peak), 0);

      // Peak window edges.
      load_tod(419);
      repeat (4) step();
      check("t5_tod420", 32'(tod_min), 420);
      check("t5_peak_lag", 32'(peak), 0);
      step();
      check("t5_peak_on", 32'(peak), 1);
      load_tod(599);
      repeat (4) step();
      check("t5_tod600", 32'(tod_min), 600);
      check("t5_peak_hold", 32'(peak), 1);
      step();
      check("t5_peak_off", 32'(peak), 0);
      load_tod(1500);
      check("t5_clamp", 32'(tod_min), 0);

      // Overrides.
      load_tod(450);
      step();
      check("t6_window", 32'(peak), 1);
      fo = 1; step();
      check("t6_offpeak", 32'(peak), 0);
      fp = 1; step();
      check("t6_force_priority", 32'(peak), 1);
      fp = 0; fo = 0; step();
      check("t6_release", 32'(peak), 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(5) == 0) s1r = ~s1r;
         if ($urandom_range(4) == 0) s2r = ~s2r;
         tod_load     = ($urandom_range(40) == 0);
         tod_load_min = 11'($urandom_range(2047));
         fp           = ($urandom_range(15) == 0);
         fo           = ($urandom_range(7) == 0);
         step();
      end
      tod_load = 0; fp = 0; fo = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
